// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud ratio helper,
// common to axis_uart_rx and axis_uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic int unsigned baud_ratio(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream interface carrying tdata/tvalid/tready.
interface axis_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a
// configurable reset value so idle-high lines come out of reset idle.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/axis_uart_rx.sv
// UART receiver (8N1-style, LSB first) presenting each good frame on an
// AXI-Stream master; framing errors and overruns are one-cycle pulses.
module axis_uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 27_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic   clk_i,
  input  logic   arstn_i,
  input  logic   rx_i,
  output logic   frame_err_o,
  output logic   overrun_o,
  axis_if.master m_axis
);

  localparam int unsigned RATIO = baud_ratio(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF  = RATIO / 2;
  localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned BW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(RATIO - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);

  uart_state_t           state;
  logic [CW-1:0]         baud_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  rx_s;
  logic                  rx_prev;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk_i),
    .rst_n (arstn_i),
    .d     (rx_i),
    .q     (rx_s)
  );

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      rx_prev     <= 1'b1;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      rx_prev     <= rx_s;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;

      // A load in STOP below overrides this clear in the same cycle.
      if (tvalid_q && m_axis.tready)
        tvalid_q <= 1'b0;

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          // Edge-triggered so a held-low break cannot retrigger a frame.
          if (rx_prev && !rx_s)
            state <= START;
        end

        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rx_s ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[DATA_WIDTH-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            // Leave at mid-stop so a back-to-back start edge is not missed.
            state    <= IDLE;
            if (rx_s) begin
              if (!tvalid_q || m_axis.tready) begin
                tdata_q  <= shreg;
                tvalid_q <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              frame_err_o <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule
